// File: rtl/vga_pixel_renderer.sv
// vga_pixel_renderer: turns the generator's sync and pixel coordinates into VGA
// colour and sync outputs. It draws a white play-field border, a dark-blue
// background and a green player box that buttons move once per frame. Sync is
// delayed through the same two stages as colour so the two stay aligned.
module vga_pixel_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 4,
    parameter int BORDER   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       horizontalVGA,
    input  logic       verticalVGA,
    input  logic [9:0] pixelX,
    input  logic [9:0] pixelY,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    output logic       hsyncOut,
    output logic       vsyncOut,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frameTick
);

    // Geometry is handled at 11 bits so that sums such as boxX+BOX_SIZE cannot wrap.
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [10:0] BORDER_W = 11'(BORDER);
    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BORDER - BOX_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BORDER - BOX_SIZE);
    localparam logic [9:0]  X_INIT   = 10'(H_ACTIVE / 2 - BOX_SIZE / 2);
    localparam logic [9:0]  Y_INIT   = 10'(V_ACTIVE / 2 - BOX_SIZE / 2);

    localparam logic [11:0] COL_OFF    = 12'h000;
    localparam logic [11:0] COL_BOX    = 12'h0F0;
    localparam logic [11:0] COL_BORDER = 12'hFFF;
    localparam logic [11:0] COL_BG     = 12'h004;

    // Button synchronisers; bit order {up, down, left, right}.
    logic [3:0]  btnMeta_r;
    logic [3:0]  btnSync_r;
    logic        vsPrev_r;
    logic [9:0]  boxX_r;
    logic [9:0]  boxY_r;
    logic [9:0]  s1X_r;
    logic [9:0]  s1Y_r;
    logic        s1Hs_r;
    logic        s1Vs_r;
    logic        s1Active_r;

    logic        frameEdge_s;
    logic [9:0]  nextBoxX_s;
    logic [9:0]  nextBoxY_s;
    logic [10:0] boxXw_s;
    logic [10:0] boxYw_s;
    logic [10:0] pixXw_s;
    logic [10:0] pixYw_s;
    logic        boxHit_s;
    logic        borderHit_s;
    logic [11:0] colour_s;

    // Bring the asynchronous buttons into the clock domain through two flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btnMeta_r <= 4'b0000;
            btnSync_r <= 4'b0000;
        end else begin
            btnMeta_r <= {btnUp, btnDown, btnLeft, btnRight};
            btnSync_r <= btnMeta_r;
        end
    end

    // Detect the vsync falling edge and work out the clamped box position for it.
    always_comb begin
        frameEdge_s = vsPrev_r & ~verticalVGA;
        boxXw_s     = {1'b0, boxX_r};
        boxYw_s     = {1'b0, boxY_r};
        nextBoxX_s  = boxX_r;
        nextBoxY_s  = boxY_r;
        if (frameEdge_s) begin
            if (btnSync_r[1] && !btnSync_r[0]) begin
                if (boxXw_s < BORDER_W + STEP_W) begin
                    nextBoxX_s = 10'(BORDER_W);
                end else begin
                    nextBoxX_s = 10'(boxXw_s - STEP_W);
                end
            end else if (btnSync_r[0] && !btnSync_r[1]) begin
                if (boxXw_s + STEP_W > X_MAX) begin
                    nextBoxX_s = 10'(X_MAX);
                end else begin
                    nextBoxX_s = 10'(boxXw_s + STEP_W);
                end
            end else begin
                nextBoxX_s = boxX_r;
            end
            if (btnSync_r[3] && !btnSync_r[2]) begin
                if (boxYw_s < BORDER_W + STEP_W) begin
                    nextBoxY_s = 10'(BORDER_W);
                end else begin
                    nextBoxY_s = 10'(boxYw_s - STEP_W);
                end
            end else if (btnSync_r[2] && !btnSync_r[3]) begin
                if (boxYw_s + STEP_W > Y_MAX) begin
                    nextBoxY_s = 10'(Y_MAX);
                end else begin
                    nextBoxY_s = 10'(boxYw_s + STEP_W);
                end
            end else begin
                nextBoxY_s = boxY_r;
            end
        end else begin
            nextBoxX_s = boxX_r;
            nextBoxY_s = boxY_r;
        end
    end

    // Frame edge tracking, frame pulse and box position registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsPrev_r  <= 1'b1;
            frameTick <= 1'b0;
            boxX_r    <= X_INIT;
            boxY_r    <= Y_INIT;
        end else begin
            vsPrev_r  <= verticalVGA;
            frameTick <= frameEdge_s;
            boxX_r    <= nextBoxX_s;
            boxY_r    <= nextBoxY_s;
        end
    end

    // Stage 1: capture coordinates and syncs, and flag the visible area.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1X_r      <= 10'd0;
            s1Y_r      <= 10'd0;
            s1Hs_r     <= 1'b1;
            s1Vs_r     <= 1'b1;
            s1Active_r <= 1'b0;
        end else begin
            s1X_r      <= pixelX;
            s1Y_r      <= pixelY;
            s1Hs_r     <= horizontalVGA;
            s1Vs_r     <= verticalVGA;
            s1Active_r <= ({1'b0, pixelX} < H_ACT_W) && ({1'b0, pixelY} < V_ACT_W);
        end
    end

    // Pick the colour of the stage-1 pixel: blanking, then box, then border, then background.
    always_comb begin
        pixXw_s     = {1'b0, s1X_r};
        pixYw_s     = {1'b0, s1Y_r};
        boxHit_s    = (pixXw_s >= boxXw_s) && (pixXw_s < boxXw_s + BOX_W) &&
                      (pixYw_s >= boxYw_s) && (pixYw_s < boxYw_s + BOX_W);
        borderHit_s = (pixXw_s < BORDER_W) || (pixXw_s >= H_ACT_W - BORDER_W) ||
                      (pixYw_s < BORDER_W) || (pixYw_s >= V_ACT_W - BORDER_W);
        colour_s    = COL_BG;
        if (!s1Active_r) begin
            colour_s = COL_OFF;
        end else if (boxHit_s) begin
            colour_s = COL_BOX;
        end else if (borderHit_s) begin
            colour_s = COL_BORDER;
        end else begin
            colour_s = COL_BG;
        end
    end

    // Stage 2: registered colour and syncs driving the connector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsyncOut <= 1'b1;
            vsyncOut <= 1'b1;
            red      <= 4'h0;
            green    <= 4'h0;
            blue     <= 4'h0;
        end else begin
            hsyncOut <= s1Hs_r;
            vsyncOut <= s1Vs_r;
            red      <= colour_s[11:8];
            green    <= colour_s[7:4];
            blue     <= colour_s[3:0];
        end
    end

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Directed and randomised bench for vga_pixel_renderer with a behavioural model
// of the box position and the frame colour map.
module tb_vga_pixel_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       horizontalVGA;
    logic       verticalVGA;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       btnUp, btnDown, btnLeft, btnRight;
    logic       hsyncOut, vsyncOut;
    logic [3:0] red, green, blue;
    logic       frameTick;

    int passCnt  = 0;
    int totalCnt = 0;
    int mBoxX;
    int mBoxY;

    vga_pixel_renderer dut (
        .clk(clk), .reset(reset),
        .horizontalVGA(horizontalVGA), .verticalVGA(verticalVGA),
        .pixelX(pixelX), .pixelY(pixelY),
        .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
        .hsyncOut(hsyncOut), .vsyncOut(vsyncOut),
        .red(red), .green(green), .blue(blue), .frameTick(frameTick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Colour the spec's rules assign to pixel (x,y) with the box at (bx,by).
    function automatic logic [11:0] expColour(input int x, input int y, input int bx, input int by);
        if (x >= 640 || y >= 480) return 12'h000;
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 12'h0F0;
        if (x < 8 || x >= 632 || y < 8 || y >= 472) return 12'hFFF;
        return 12'h004;
    endfunction

    // Present a pixel and check the colour two cycles later.
    task automatic pix(input string tag, input int x, input int y);
        pixelX = 10'(x);
        pixelY = 10'(y);
        tick();
        tick();
        check(tag, {20'h0, red, green, blue}, {20'h0, expColour(x, y, mBoxX, mBoxY)});
    endtask

    // One vsync falling edge with the given buttons held; updates the model.
    task automatic frame(input logic u, input logic d, input logic l, input logic r);
        btnUp = u; btnDown = d; btnLeft = l; btnRight = r;
        repeat (4) tick();
        verticalVGA = 1'b0;
        tick();
        check("frameTick_high", {31'h0, frameTick}, 32'h1);
        if (l && !r) mBoxX = (mBoxX - 4 < 8) ? 8 : mBoxX - 4;
        if (r && !l) mBoxX = (mBoxX + 4 > 600) ? 600 : mBoxX + 4;
        if (u && !d) mBoxY = (mBoxY - 4 < 8) ? 8 : mBoxY - 4;
        if (d && !u) mBoxY = (mBoxY + 4 > 440) ? 440 : mBoxY + 4;
        tick();
        check("frameTick_low", {31'h0, frameTick}, 32'h0);
        verticalVGA = 1'b1;
        tick();
    endtask

    task automatic checkBox(input string tag);
        check({tag, "_boxX"}, 32'(dut.boxX_r), 32'(mBoxX));
        check({tag, "_boxY"}, 32'(dut.boxY_r), 32'(mBoxY));
    endtask

    initial begin
        reset = 1'b0; horizontalVGA = 1'b1; verticalVGA = 1'b1;
        pixelX = 10'd0; pixelY = 10'd0;
        btnUp = 1'b0; btnDown = 1'b0; btnLeft = 1'b0; btnRight = 1'b0;
        mBoxX = 304; mBoxY = 224;

        // Reset held for four cycles.
        repeat (4) tick();
        check("rst_hsync", {31'h0, hsyncOut}, 32'h1);
        check("rst_vsync", {31'h0, vsyncOut}, 32'h1);
        check("rst_rgb", {20'h0, red, green, blue}, 32'h0);
        check("rst_frameTick", {31'h0, frameTick}, 32'h0);
        checkBox("rst");

        // Release: first pixel lands exactly two cycles later.
        reset = 1'b1; pixelX = 10'd0; pixelY = 10'd0; horizontalVGA = 1'b0;
        tick();
        check("lat1_hsync", {31'h0, hsyncOut}, 32'h1);
        check("lat1_rgb", {20'h0, red, green, blue}, 32'h0);
        tick();
        check("lat2_hsync", {31'h0, hsyncOut}, 32'h0);
        check("lat2_rgb", {20'h0, red, green, blue}, 32'hFFF);
        horizontalVGA = 1'b1;
        tick();

        // Box hit and just past its right edge.
        pix("box_corner", 304, 224);
        pix("box_right_out", 336, 224);
        pix("box_last", 335, 255);
        pix("box_below", 304, 256);

        // Three frames moving right.
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("right3_boxX", 32'(dut.boxX_r), 32'd316);
        checkBox("right3");

        // Clamp at all limits.
        for (int i = 0; i < 100; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("left_clamp", 32'(dut.boxX_r), 32'd8);
        pix("box_at_left", 8, 224);
        pix("border_left", 7, 224);
        for (int i = 0; i < 200; i++) frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("right_clamp", 32'(dut.boxX_r), 32'd600);
        pix("box_at_right", 631, 230);
        pix("border_right", 632, 230);
        for (int i = 0; i < 100; i++) frame(1'b0, 1'b1, 1'b0, 1'b0);
        check("down_clamp", 32'(dut.boxY_r), 32'd440);
        pix("box_at_bottom", 610, 471);
        pix("border_bottom", 610, 472);
        for (int i = 0; i < 120; i++) frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("up_clamp", 32'(dut.boxY_r), 32'd8);

        // Opposing buttons cancel.
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, 1'b1, 1'b1);
        checkBox("opposed");

        // Blanking region.
        pix("blank_x", 700, 100);
        pix("blank_y", 100, 500);
        pix("blank_xy", 799, 524);
        pix("background", 320, 300);

        // Randomised button frames with colour probes around the box.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            frame(r[3], r[2], r[1], r[0]);
            pix("rand_any", int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            pix("rand_near", mBoxX - 4 + int'($urandom_range(0, 40)),
                mBoxY - 4 + int'($urandom_range(0, 40)));
            pix("rand_near2", mBoxX - 2 + int'($urandom_range(0, 36)),
                mBoxY - 2 + int'($urandom_range(0, 36)));
        end
        checkBox("rand_end");

        // Reset asserted mid-line with non-idle outputs.
        horizontalVGA = 1'b0; verticalVGA = 1'b0;
        pixelX = 10'd100; pixelY = 10'd100;
        tick();
        tick();
        reset = 1'b0;
        tick();
        mBoxX = 304; mBoxY = 224;
        check("mid_rst_hsync", {31'h0, hsyncOut}, 32'h1);
        check("mid_rst_vsync", {31'h0, vsyncOut}, 32'h1);
        check("mid_rst_rgb", {20'h0, red, green, blue}, 32'h0);
        check("mid_rst_frameTick", {31'h0, frameTick}, 32'h0);
        checkBox("mid_rst");

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
